// File: rtl/data_memory_ctrl_if.sv
// Bus between the RV32I datapath and the data memory controller.
// Optional feature macro: DMEM_STORE_COUNT_EN adds the StoreCount signal.
interface data_memory_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        busy;
    logic        misaligned;
`ifdef DMEM_STORE_COUNT_EN
    logic [15:0] StoreCount;
`endif

    // Core side: issues loads and stores.
    modport master (
        output MemRead, MemWrite, Funct3, Address, WriteData,
        input  ReadData, busy, misaligned
`ifdef DMEM_STORE_COUNT_EN
        , input StoreCount
`endif
    );

    // Memory side: serves loads and stores.
    modport slave (
        input  MemRead, MemWrite, Funct3, Address, WriteData,
        output ReadData, busy, misaligned
`ifdef DMEM_STORE_COUNT_EN
        , output StoreCount
`endif
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory for the single-cycle RV32I core.
// Combinational byte/half/word loads, byte-lane stores, misalignment detection
// with a sticky flag, and a post-reset clear engine that zeroes the array.
// Optional feature macro: DMEM_STORE_COUNT_EN adds a saturating count of
// committed stores on the StoreCount signal of the bus.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          misaligned_q, misaligned_d;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          busy;
    logic [AW-1:0] word;
    logic [1:0]    lane;
    logic          mis_access;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;
    logic          store_commit;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   read_data;
    logic          unused_addr_bits;

    // Upper address bits alias onto the array on purpose.
    assign unused_addr_bits = ^bus.Address[31:AW+2];

    // State register: clear engine position and sticky misalignment flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (reset) begin
            state_q      <= S_CLEAR;
            idx_q        <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state logic: walk every word once, then stay READY until reset.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == S_CLEAR) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == AW'(DEPTH_WORDS - 1)) begin
                state_d = S_READY;
            end
        end
    end

    // Output logic: accesses are locked out while the clear engine runs.
    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    // Access decode: word/lane select, misalignment, store lane mask and data.
    always_comb begin
        word       = bus.Address[AW+1:2];
        lane       = bus.Address[1:0];
        mis_access = 1'b0;
        wr_mask    = 4'b0000;
        wr_data    = bus.WriteData;
        case (bus.Funct3[1:0])
            2'b00: begin
                wr_mask = 4'b0001 << lane;
                wr_data = {4{bus.WriteData[7:0]}};
            end
            2'b01: begin
                mis_access = lane[0];
                wr_mask    = lane[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{bus.WriteData[15:0]}};
            end
            2'b10: begin
                mis_access = (lane != 2'b00);
                wr_mask    = 4'b1111;
            end
            default: ;
        endcase
        store_commit = bus.MemWrite && !busy && !mis_access && (wr_mask != 4'b0000);
        misaligned_d = misaligned_q
                     | ((bus.MemRead | bus.MemWrite) && !busy && mis_access);
    end

    // Array write port: clear engine while busy, byte-lane stores once ready.
    always_ff @(posedge clk) begin
        // NOTE: the array itself has no reset; the clear engine zeroes it
        // one word per cycle so it can map onto plain RAM.
        if (!reset) begin
            if (busy) begin
                mem[idx_q] <= '0;
            end else if (store_commit) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_mask[i]) begin
                        mem[word][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read path: combinational, shows pre-edge contents on a same-word store.
    always_comb begin
        rd_word  = mem[word];
        rd_shift = rd_word >> {lane, 3'b000};
        case (bus.Funct3)
            3'b000:  read_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  read_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  read_data = rd_word;
            3'b100:  read_data = {24'd0, rd_shift[7:0]};
            3'b101:  read_data = {16'd0, rd_shift[15:0]};
            default: read_data = '0;
        endcase
        if (busy || mis_access) begin
            read_data = '0;
        end
    end

    assign bus.ReadData   = read_data;
    assign bus.busy       = busy;
    assign bus.misaligned = misaligned_q;

`ifdef DMEM_STORE_COUNT_EN
    logic [15:0] store_count_q, store_count_d;

    // Store counter next value: saturates at all-ones.
    always_comb begin
        store_count_d = store_count_q;
        if (store_commit && (store_count_q != 16'hFFFF)) begin
            store_count_d = store_count_q + 16'd1;
        end
    end

    // Store counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_count_q <= '0;
        end else begin
            store_count_q <= store_count_d;
        end
    end

    assign bus.StoreCount = store_count_q;
`endif
endmodule
